// File: rtl/lock_pkg.sv
// Shared types and constants for the combination lock: FSM states, digit type, factory code.
package lock_pkg;

    localparam int CODE_LEN_DEFAULT = 4;

    typedef logic [2:0] digit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_OPEN,
        S_PROG,
        S_LOCKOUT
    } state_e;

    localparam digit_t DEFAULT_COMB [CODE_LEN_DEFAULT] = '{3'b101, 3'b110, 3'b011, 3'b101};

    // Longer codes repeat the factory pattern so any CODE_LEN has a defined reset value.
    function automatic digit_t default_digit(input int i);
        return DEFAULT_COMB[i % CODE_LEN_DEFAULT];
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counting interval timer: load seeds the count, done marks the last cycle of the interval.
module lock_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign done = en && !load && (count_q == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lock_sequencer.sv
// Digit-combination lock with open timer, in-field reprogramming and optional failure lockout.
// Optional feature: define LOCK_LOCKOUT_EN to enable the LOCKOUT state after MAX_FAILS bad attempts.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = CODE_LEN_DEFAULT,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entry_valid,
    input  logic [2:0] entry,
    input  logic       prog,
    output logic       unlock,
    output logic       lockout,
    output logic [1:0] fail_cnt
);

    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int OPEN_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [1:0]       MAX_FAIL2 = 2'(MAX_FAILS);

    state_e            state_d, state_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic              match_d, match_q;
    logic [1:0]        fail_d, fail_q;
    digit_t            comb_d [CODE_LEN];
    digit_t            comb_q [CODE_LEN];
    logic              unlock_d, unlock_q;
    logic              lockout_d, lockout_q;
    logic              attempt_done;
    logic              open_load, open_done;
    logic              lock_load, lock_done;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        match_d      = match_q;
        fail_d       = fail_q;
        comb_d       = comb_q;
        attempt_done = 1'b0;
        open_load    = 1'b0;
        lock_load    = 1'b0;

        case (state_q)
            S_IDLE: if (entry_valid) begin
                match_d      = (entry == comb_q[0]);
                idx_d        = 1'b1;
                state_d      = S_ENTER;
                attempt_done = (CODE_LEN == 1);
            end
            S_ENTER: if (entry_valid) begin
                match_d      = match_q && (entry == comb_q[idx_q]);
                idx_d        = idx_q + 1'b1;
                attempt_done = (idx_q == LAST_IDX);
            end
            S_OPEN: begin
                if (prog) begin
                    state_d = S_PROG;
                end else if (open_done) begin
                    state_d = S_IDLE;
                end
            end
            S_PROG: if (entry_valid) begin
                comb_d[idx_q] = entry;
                idx_d         = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: if (lock_done) begin
                state_d = S_IDLE;
                fail_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // A wrong digit only surfaces here, once the full code length has been keyed in.
        if (attempt_done) begin
            if (match_d) begin
                state_d   = S_OPEN;
                fail_d    = '0;
                open_load = 1'b1;
            end else begin
                fail_d  = (fail_q == MAX_FAIL2) ? fail_q : fail_q + 2'd1;
                state_d = S_IDLE;
`ifdef LOCK_LOCKOUT_EN
                if (fail_d == MAX_FAIL2) begin
                    state_d   = S_LOCKOUT;
                    lock_load = 1'b1;
                end
`endif
            end
        end

        // Any state change other than starting an attempt discards the digit position.
        if ((state_d != state_q) && (state_d != S_ENTER)) begin
            idx_d = '0;
        end
    end

    assign unlock_d = (state_d == S_OPEN) || (state_d == S_PROG);
`ifdef LOCK_LOCKOUT_EN
    assign lockout_d = (state_d == S_LOCKOUT);
`else
    assign lockout_d = 1'b0;
`endif

    // NOTE: the combination store is reset like any other flop, since reset must restore the factory code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            match_q   <= 1'b0;
            fail_q    <= '0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
            for (int i = 0; i < CODE_LEN; i++) begin
                comb_q[i] <= default_digit(i);
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            match_q   <= match_d;
            fail_q    <= fail_d;
            unlock_q  <= unlock_d;
            lockout_q <= lockout_d;
            comb_q    <= comb_d;
        end
    end

    lock_timer #(.WIDTH(OPEN_W)) u_open_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (open_load),
        .load_val (OPEN_W'(UNLOCK_CYCLES - 1)),
        .en       ((state_q == S_OPEN) && !prog),
        .done     (open_done)
    );

    lock_timer #(.WIDTH(LOCK_W)) u_lock_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (lock_load),
        .load_val (LOCK_W'(LOCKOUT_CYCLES - 1)),
        .en       (state_q == S_LOCKOUT),
        .done     (lock_done)
    );

    assign unlock   = unlock_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus randomized attempts against a code/fail-count model.
module tb_lock_sequencer;

    localparam int CODE_LEN       = 4;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 16;
`ifdef LOCK_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       entry_valid;
    logic [2:0] entry;
    logic       prog;
    logic       unlock;
    logic       lockout;
    logic [1:0] fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the combination currently stored and the consecutive-failure count.
    int model_comb [CODE_LEN];
    int model_fails;
    int def_code   [CODE_LEN] = '{5, 6, 3, 5};
    int new_code   [CODE_LEN] = '{7, 0, 7, 0};
    int bad_code   [CODE_LEN] = '{0, 6, 3, 5};

    always #5 clock = ~clock;

    lock_sequencer #(
        .CODE_LEN       (CODE_LEN),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .entry_valid (entry_valid),
        .entry       (entry),
        .prog        (prog),
        .unlock      (unlock),
        .lockout     (lockout),
        .fail_cnt    (fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic strobe(input int d);
        entry       = 3'(d);
        entry_valid = 1'b1;
        @(negedge clock);
        entry_valid = 1'b0;
    endtask

    task automatic enter_code(input int d [CODE_LEN]);
        for (int i = 0; i < CODE_LEN; i++) begin
            strobe(d[i]);
            if (i < CODE_LEN - 1) repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    task automatic make_wrong(output int d [CODE_LEN]);
        int pos;
        for (int i = 0; i < CODE_LEN; i++) d[i] = $urandom_range(0, 7);
        pos    = $urandom_range(0, CODE_LEN - 1);
        d[pos] = (model_comb[pos] + 1 + $urandom_range(0, 6)) % 8;
    endtask

    // Runs one full attempt; returns at a negedge with the lock back in its idle condition.
    task automatic attempt(input int d [CODE_LEN], input string tag);
        bit ok = 1'b1;
        int hi = 0;
        for (int i = 0; i < CODE_LEN; i++) if (d[i] != model_comb[i]) ok = 1'b0;
        enter_code(d);
        if (ok) begin
            model_fails = 0;
            check({tag, ":unlock_first"}, unlock, 1);
            check({tag, ":fail_cnt_open"}, fail_cnt, 0);
            for (int c = 0; c < UNLOCK_CYCLES + 4 && unlock === 1'b1; c++) begin
                hi++;
                if ($urandom_range(0, 1) == 1) begin
                    entry       = 3'($urandom);
                    entry_valid = 1'b1;
                end
                @(negedge clock);
                entry_valid = 1'b0;
            end
            check({tag, ":open_len"}, hi, UNLOCK_CYCLES);
            check({tag, ":lockout_after_open"}, lockout, 0);
        end else begin
            if (model_fails < MAX_FAILS) model_fails++;
            check({tag, ":unlock_bad"}, unlock, 0);
            check({tag, ":fail_cnt_bad"}, fail_cnt, model_fails);
            if (LOCKOUT_EN && model_fails == MAX_FAILS) begin
                check({tag, ":lockout_first"}, lockout, 1);
                for (int c = 0; c < LOCKOUT_CYCLES + 4 && lockout === 1'b1; c++) begin
                    hi++;
                    entry       = 3'(model_comb[c % CODE_LEN]);
                    entry_valid = 1'b1;
                    @(negedge clock);
                    entry_valid = 1'b0;
                end
                model_fails = 0;
                check({tag, ":lockout_len"}, hi, LOCKOUT_CYCLES);
                check({tag, ":fail_cnt_after_lockout"}, fail_cnt, 0);
                check({tag, ":unlock_after_lockout"}, unlock, 0);
            end else begin
                check({tag, ":lockout_bad"}, lockout, 0);
            end
        end
    endtask

    initial begin
        int wrong [CODE_LEN];
        reset       = 1'b1;
        entry_valid = 1'b0;
        entry       = 3'd0;
        prog        = 1'b0;
        model_comb  = def_code;
        model_fails = 0;
        #1;
        check("reset_unlock", unlock, 0);
        check("reset_lockout", lockout, 0);
        check("reset_fail_cnt", fail_cnt, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        attempt(def_code, "default_open");
        attempt(bad_code, "first_digit_wrong");
        attempt(def_code, "open_after_fail");

        repeat (LOCKOUT_EN ? MAX_FAILS : MAX_FAILS + 2) begin
            make_wrong(wrong);
            attempt(wrong, "repeated_wrong");
        end
        check("fails_sat_or_cleared", fail_cnt, LOCKOUT_EN ? 0 : MAX_FAILS);
        attempt(def_code, "open_after_wrong_run");

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) attempt(model_comb, "rand_good");
            else begin
                make_wrong(wrong);
                attempt(wrong, "rand_bad");
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Reprogram from OPEN; the entry strobe coinciding with prog must not be stored.
        if (model_fails != 0) attempt(model_comb, "open_before_prog");
        enter_code(model_comb);
        model_fails = 0;
        check("prog_pre_open", unlock, 1);
        repeat (3) @(negedge clock);
        prog        = 1'b1;
        entry_valid = 1'b1;
        entry       = 3'd3;
        @(negedge clock);
        prog        = 1'b0;
        entry_valid = 1'b0;
        check("prog_unlock_held", unlock, 1);
        repeat (UNLOCK_CYCLES + 2) @(negedge clock);
        check("prog_timer_frozen", unlock, 1);
        enter_code(new_code);
        model_comb = new_code;
        check("prog_done_unlock", unlock, 0);
        check("prog_done_fail_cnt", fail_cnt, 0);
        attempt(def_code, "old_code_after_prog");
        attempt(new_code, "new_code_after_prog");

        // Reset mid-entry restores the factory code and clears the failure count.
        strobe(new_code[0]);
        strobe(new_code[1]);
        #2 reset = 1'b1;
        #1;
        check("midentry_reset_fail_cnt", fail_cnt, 0);
        check("midentry_reset_unlock", unlock, 0);
        @(negedge clock);
        reset       = 1'b0;
        model_comb  = def_code;
        model_fails = 0;
        @(negedge clock);
        attempt(new_code, "new_code_after_reset");
        attempt(def_code, "default_after_reset");

        // Reset while open drops unlock without waiting for an edge.
        enter_code(def_code);
        check("open_before_reset", unlock, 1);
        #2 reset = 1'b1;
        #1;
        check("open_reset_unlock", unlock, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        attempt(def_code, "open_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter CODE_LEN, default 4, number of 3-bit digits in a combination.
REQ-002 Parameter UNLOCK_CYCLES, default 8, clock cycles the lock stays open.
REQ-003 Parameter MAX_FAILS, default 3, consecutive failed attempts that trigger lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 16, clock cycles of lockout.
REQ-005 Port clock  input  1  single clock; all state updates on the rising edge.
REQ-006 Port reset  input  1  reset, asynchronous, active-high.
REQ-007 Port entry_valid  input  1  one-cycle strobe: entry holds a digit.
REQ-008 Port entry  input  3  digit {a,b,c}, sampled only when entry_valid=1.
REQ-009 Port prog  input  1  request to reprogram the combination; honoured only in OPEN.
REQ-010 Port unlock  output  1  1 = lock open; registered.
REQ-011 Port lockout  output  1  1 = entries currently ignored due to failures; registered.
REQ-012 Port fail_cnt  output  2  consecutive failed attempts, saturating at MAX_FAILS.

Function
REQ-013 The FSM SHALL have states IDLE, ENTER, OPEN, PROG, LOCKOUT.
REQ-014 IDLE: on entry_valid, latch match=(entry==comb[0]), set idx=1, go to ENTER.
REQ-015 ENTER: each entry_valid ANDs (entry==comb[idx]) into match and increments idx; a wrong digit does not abort the attempt early.
REQ-016 When the CODE_LEN-th digit is accepted at edge N with all digits matching, state SHALL be OPEN after edge N, fail_cnt cleared, and unlock=1 for exactly UNLOCK_CYCLES cycles following edge N.
REQ-017 On a mismatched attempt, fail_cnt SHALL increment (saturating); go to LOCKOUT if it reaches MAX_FAILS, else to IDLE.
REQ-018 OPEN: entry_valid ignored; on timer expiry return to IDLE with unlock=0.
REQ-019 OPEN with prog=1: go to PROG, unlock held at 1, open timer frozen; prog wins over a simultaneous entry_valid, which is not consumed.
REQ-020 PROG: the next CODE_LEN entry_valid digits SHALL be written to comb[0..CODE_LEN-1] in order; after the last write go to IDLE and deassert unlock on the next edge.
REQ-021 LOCKOUT: lockout=1, entry_valid ignored and not counted, for exactly LOCKOUT_CYCLES cycles; then IDLE with fail_cnt=0 and lockout=0.
REQ-022 idx SHALL wrap to 0 whenever the FSM returns to IDLE; no partial attempt survives a state change.
REQ-023 Timers SHALL be sized by $clog2 of their parameter and reload on state entry.

Reset
REQ-024 Assertion of reset SHALL immediately force IDLE, unlock=0, lockout=0, fail_cnt=0, idx=0, match=0, timers=0.
REQ-025 Reset SHALL restore comb to the default combination 101,110,011,101; a reset mid-entry, mid-program or mid-lockout discards all progress.

Configuration
REQ-026 Macro LOCK_LOCKOUT_EN defined: LOCKOUT state and behaviour per REQ-017/REQ-021.
REQ-027 Macro LOCK_LOCKOUT_EN undefined: no LOCKOUT state, lockout tied 0, failed attempts return to IDLE, fail_cnt still counts and saturates.

Structure
REQ-028 Package lock_pkg SHALL hold the state enum, digit_t (3-bit) typedef, CODE_LEN default, and the default combination constant.
REQ-029 Sub-module lock_timer (load, count value, done pulse) SHALL implement both the open and lockout timers as two instances.

Verification
REQ-030 Reset, then digits 101,110,011,101 -> unlock=1 for exactly 8 cycles starting the cycle after the 4th strobe; fail_cnt=0.
REQ-031 Digits 000,110,011,101 -> unlock stays 0, fail_cnt=1, FSM back in IDLE after 4th digit.
REQ-032 Three wrong attempts (LOCK_LOCKOUT_EN) -> lockout=1 for 16 cycles; a correct code during lockout ignored; afterwards fail_cnt=0 and correct code opens.
REQ-033 Open, prog=1 with entry_valid same cycle, program 111,000,111,000 -> old code fails, new code opens.
REQ-034 Reset asserted after 2 correct digits, then reprogrammed code entered -> fails; default code then opens.
REQ-035 Without LOCK_LOCKOUT_EN, 5 wrong attempts -> lockout never 1, fail_cnt saturates at 3.
